// File: rtl/axis_code_loader.sv
// axis_code_loader: AXI-Stream program loader into code RAM with a registered fetch port.
module axis_code_loader #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int INSTR_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INSTR_WIDTH-1:0]     prog_TDATA,
    input  logic                       prog_TVALID,
    output logic                       prog_TREADY,
    input  logic                       prog_TLAST,
    input  logic                       inst_rd_en,
    input  logic [CODE_ADDR_WIDTH-1:0] PC,
    output logic [INSTR_WIDTH-1:0]     instr_out,
    output logic                       code_vld,
    output logic [CODE_ADDR_WIDTH:0]   code_len,
    output logic                       load_err
);
    localparam int AW    = CODE_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READY} state_t;
    state_t                 r_state, w_state_n;
    logic                   r_rdy, r_err, w_err_n, w_we, w_beat;
    logic [AW-1:0]          r_wr_addr, w_wr_addr_n, w_waddr;
    logic [AW:0]            r_len, w_len_n;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
    logic [INSTR_WIDTH-1:0] r_instr;
    assign w_beat      = prog_TVALID && r_rdy;
    assign prog_TREADY = r_rdy;
    assign instr_out   = r_instr;
    assign code_vld    = (r_state == READY);
    assign code_len    = r_len;
    assign load_err    = r_err;
    always_comb begin
        w_state_n   = r_state;
        w_wr_addr_n = r_wr_addr;
        w_len_n     = r_len;
        w_err_n     = r_err;
        w_we        = 1'b0;
        w_waddr     = r_wr_addr;
        case (r_state)
            IDLE, READY: if (w_beat) begin
                w_we        = 1'b1;
                w_waddr     = '0;
                w_wr_addr_n = AW'(1);
                w_err_n     = 1'b0;
                w_len_n     = prog_TLAST ? (AW+1)'(1) : r_len;
                w_state_n   = prog_TLAST ? READY : LOAD;
            end
            LOAD: if (w_beat) begin
                w_we        = 1'b1;
                w_wr_addr_n = r_wr_addr + AW'(1);
                if (prog_TLAST) begin
                    w_len_n   = {1'b0, r_wr_addr} + (AW+1)'(1);
                    w_err_n   = 1'b0;
                    w_state_n = READY;
                end else if (r_wr_addr == '1) begin
                    // RAM full: last slot is written, the rest of the image is drained
                    w_len_n   = (AW+1)'(DEPTH);
                    w_err_n   = 1'b1;
                    w_state_n = DRAIN;
                end
            end
            DRAIN: w_state_n = (w_beat && prog_TLAST) ? READY : DRAIN;
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rdy     <= 1'b0;
            r_wr_addr <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_rdy     <= 1'b1;
            r_wr_addr <= w_wr_addr_n;
            r_len     <= w_len_n;
            r_err     <= w_err_n;
        end
    end
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= prog_TDATA;
    end
    // Reads happen only in READY; a same-cycle reload write returns the old word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_instr <= '0;
        else if (inst_rd_en && r_state == READY) r_instr <= r_mem[PC];
    end
endmodule

// File: tb/tb_axis_code_loader.sv
// tb_axis_code_loader: directed scoreboard bench for axis_code_loader at depth 16.
module tb_axis_code_loader;
    localparam int AW = 4;
    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    prog_TDATA;
    logic          prog_TVALID, prog_TLAST, prog_TREADY;
    logic          inst_rd_en;
    logic [AW-1:0] PC;
    logic [7:0]    instr_out;
    logic          code_vld, load_err;
    logic [AW:0]   code_len;
    logic [7:0]    mem_m [16];
    logic [7:0]    exp_instr;
    logic [7:0]    q[$];
    int            n_vec = 0;
    int            n_err = 0;

    axis_code_loader #(.CODE_ADDR_WIDTH(AW), .INSTR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .prog_TDATA(prog_TDATA), .prog_TVALID(prog_TVALID), .prog_TREADY(prog_TREADY), .prog_TLAST(prog_TLAST),
        .inst_rd_en(inst_rd_en), .PC(PC), .instr_out(instr_out),
        .code_vld(code_vld), .code_len(code_len), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        prog_TDATA  = d;
        prog_TVALID = 1'b1;
        prog_TLAST  = last;
        chk("tready", prog_TREADY, 1'b1);
        tick();
        prog_TVALID = 1'b0;
        prog_TLAST  = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] pc, input bit honoured);
        PC         = pc;
        inst_rd_en = 1'b1;
        if (honoured) exp_instr = mem_m[pc];
        q.push_back(exp_instr);
        tick();
        inst_rd_en = 1'b0;
        chk($sformatf("fetch pc=%0d", pc), instr_out, q.pop_front());
    endtask

    initial begin
        rst = 1'b1; prog_TDATA = '0; prog_TVALID = 1'b0; prog_TLAST = 1'b0;
        inst_rd_en = 1'b0; PC = '0; exp_instr = '0;
        for (int i = 0; i < 16; i++) mem_m[i] = 'x;
        repeat (2) tick();
        chk("rst tready", prog_TREADY, 1'b0);
        chk("rst code_vld", code_vld, 1'b0);
        chk("rst instr_out", instr_out, 8'h00);
        chk("rst code_len", code_len, 5'd0);
        chk("rst load_err", load_err, 1'b0);
        rst = 1'b0;
        tick();
        // 1: five-word image, continuous valid
        for (int i = 0; i < 5; i++) begin
            chk("s1 code_vld low", code_vld, 1'b0);
            beat(8'(8'h11 + i), i == 4);
            mem_m[i] = 8'(8'h11 + i);
        end
        chk("s1 code_vld", code_vld, 1'b1);
        chk("s1 code_len", code_len, 5'd5);
        chk("s1 load_err", load_err, 1'b0);
        // 2: fetch and hold
        fetch(3, 1);
        PC = 0;
        tick();
        chk("s2 hold", instr_out, 8'h14);
        for (int i = 0; i < 5; i++) fetch(AW'(i), 1);
        // 3: overflow with drain
        for (int i = 0; i < 20; i++) begin
            beat(8'(8'h40 + i), i == 19);
            if (i < 16) mem_m[i] = 8'(8'h40 + i);
            if (i < 19) chk($sformatf("s3 code_vld beat%0d", i + 1), code_vld, 1'b0);
        end
        chk("s3 code_vld", code_vld, 1'b1);
        chk("s3 load_err", load_err, 1'b1);
        chk("s3 code_len", code_len, 5'd16);
        fetch(0, 1);
        fetch(15, 1);
        fetch(7, 1);
        // 4: single-beat image from IDLE
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_instr = '0;
        tick();
        beat(8'hAB, 1'b1);
        mem_m[0] = 8'hAB;
        chk("s4 code_len", code_len, 5'd1);
        chk("s4 code_vld", code_vld, 1'b1);
        chk("s4 load_err", load_err, 1'b0);
        fetch(0, 1);
        fetch(1, 1);
        // 5: gapped reload; first beat collides with a fetch of the same address
        PC = 0;
        inst_rd_en = 1'b1;
        exp_instr = mem_m[0];
        q.push_back(exp_instr);
        beat(8'h61, 1'b0);
        inst_rd_en = 1'b0;
        chk("s5 old data", instr_out, q.pop_front());
        mem_m[0] = 8'h61;
        chk("s5 code_vld drop", code_vld, 1'b0);
        for (int i = 1; i < 3; i++) begin
            fetch(AW'(i), 0);
            fetch(0, 0);
            beat(8'(8'h61 + i), i == 2);
            mem_m[i] = 8'(8'h61 + i);
        end
        chk("s5 code_len", code_len, 5'd3);
        chk("s5 code_vld", code_vld, 1'b1);
        chk("s5 load_err", load_err, 1'b0);
        fetch(1, 1);
        fetch(2, 1);
        // 6: async reset mid-load
        beat(8'h71, 1'b0);
        beat(8'h72, 1'b0);
        mem_m[0] = 8'h71;
        mem_m[1] = 8'h72;
        #3;
        rst = 1'b1;
        #1;
        chk("s6 code_vld", code_vld, 1'b0);
        chk("s6 instr_out", instr_out, 8'h00);
        chk("s6 tready", prog_TREADY, 1'b0);
        exp_instr = '0;
        tick();
        rst = 1'b0;
        tick();
        beat(8'h81, 1'b0);
        beat(8'h82, 1'b1);
        mem_m[0] = 8'h81;
        mem_m[1] = 8'h82;
        chk("s6 code_len", code_len, 5'd2);
        chk("s6 code_vld after", code_vld, 1'b1);
        fetch(0, 1);
        fetch(1, 1);
        fetch(2, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axis_code_loader.md
Name: axis_code_loader

Overview:
- Instruction memory plus AXI-Stream program loader that sits directly upstream of the CPU controller.
- Loads a program image from a byte stream into on-chip code RAM.
- Serves fetch reads to the controller: it takes inst_rd_en and the PC, and returns instr_out one cycle later.
- Gates CPU execution with code_vld while a program is being loaded.

Parameters:
- CODE_ADDR_WIDTH, 10, code RAM address width; depth = 2^CODE_ADDR_WIDTH.
- INSTR_WIDTH, 8, instruction word width, matching the controller's instruction input.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- prog_TDATA  input  INSTR_WIDTH  program word
- prog_TVALID  input  1  program beat valid
- prog_TREADY  output  1  loader ready for a program beat
- prog_TLAST  input  1  final word of program image
- inst_rd_en  input  1  fetch strobe from controller
- PC  input  CODE_ADDR_WIDTH  fetch address
- instr_out  output  INSTR_WIDTH  fetched instruction, registered
- code_vld  output  1  program loaded and fetchable; CPU may run
- code_len  output  CODE_ADDR_WIDTH+1  number of words in last completed load
- load_err  output  1  last load overflowed the RAM

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high.
- Reset values: state=IDLE, instr_out=0, code_vld=0, code_len=0, load_err=0, prog_TREADY=0. Reset does not clear RAM contents.
- FSM states: IDLE, LOAD, DRAIN, READY.
  - prog_TREADY=1 in IDLE, LOAD, DRAIN and READY, but only from the first cycle after rst deasserts.
  - A beat is accepted when prog_TVALID && prog_TREADY.
- IDLE:
  - An accepted beat writes RAM[0] and sets wr_addr=1.
  - If TLAST: code_len=1, load_err=0, go to READY.
  - Otherwise go to LOAD.
- LOAD: each accepted beat writes RAM[wr_addr] and increments wr_addr.
  - TLAST on the beat: code_len=wr_addr+1, load_err=0, go to READY.
  - Beat without TLAST at wr_addr = 2^CODE_ADDR_WIDTH-1: write it, set load_err=1, code_len=2^CODE_ADDR_WIDTH, go to DRAIN. No wrap-around write is allowed.
- DRAIN:
  - Accept and discard beats; RAM is not written.
  - The TLAST beat goes to READY with load_err still 1.
  - code_vld stays 0 through DRAIN.
- READY:
  - code_vld=1, asserted the cycle after the terminating beat.
  - An accepted beat starts a new load exactly as in IDLE. code_vld drops to 0 the same edge, and load_err clears to 0.
- code_vld=1 only in READY, including READY entered via DRAIN; the controller must check load_err separately.
- Fetch:
  - When inst_rd_en=1 and state=READY, instr_out <= RAM[PC] at the next edge (latency 1).
  - When inst_rd_en=0, instr_out holds its value.
  - When inst_rd_en=1 and state is not READY, instr_out holds its value (fetch ignored).
- Same-cycle read and write: a read is only honoured in READY, and a write in READY (first beat of a reload) also drops code_vld. Same-address conflict therefore returns the old RAM data; the controller is held off by code_vld=0.
- PC is used modulo the depth; no range check against code_len.
- Reset mid-load: FSM returns to IDLE and code_vld=0. Partially written RAM is retained but not valid. The next load restarts at address 0.
- RAM: single write port and single registered read port; infers block RAM.

Test Plan:
1. Reset, then stream 5 words 0x11..0x15 with TLAST on the 5th, TVALID continuous. Required: prog_TREADY=1 throughout; code_vld=1 the cycle after the 5th beat; code_len=5; load_err=0.
2. After scenario 1, set PC=3 and pulse inst_rd_en. Required: instr_out=0x14 on the next cycle. With inst_rd_en=0 and PC changed to 0, instr_out stays 0x14.
3. Width 4 (depth 16): stream 20 words without TLAST until the 20th. Required:
   - RAM[15] = 16th word.
   - Beats 17-20 discarded; RAM[0] still the 1st word.
   - load_err=1, code_len=16.
   - code_vld=1 only after beat 20.
4. Single-beat image 0xAB with TLAST from IDLE. Required: code_len=1, code_vld=1; fetch PC=0 returns 0xAB.
5. In READY, start a reload with TVALID gapped (1 beat every 3 cycles) for 3 words. Required: code_vld=0 from the first-beat edge; inst_rd_en pulses during the load leave instr_out unchanged; code_len=3 at the end.
6. Assert rst asynchronously mid-load after beat 2. Required: code_vld=0, instr_out=0, prog_TREADY=0 immediately. After release, a new load writes starting at address 0.
